core_exec_ctrl: RTL
===================

Name: core_exec_ctrl

Overview:
Execution controller for the single-cycle RISC-V core. It generates a per-cycle commit enable, core_en, which gates the PC register, RegisterFile write and DataMemory write. It supports run, halt and single-step modes, one PC breakpoint, and trapping on EBREAK. It also keeps cycle and retired-instruction counters for the LED/debug path.

Parameters:
PC_WIDTH, 32, width of pc and bp_addr
CNT_WIDTH, 32, width of cycle_cnt and retire_cnt
START_RUN, 0, 1 = leave reset in RUN; 0 = leave reset in HALT

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
run_req  in  1  single-cycle pulse: resume free running
halt_req  in  1  single-cycle pulse: stop before the next commit
step_req  in  1  single-cycle pulse (debounced button): execute exactly one instruction
bp_en  in  1  breakpoint enable
bp_addr  in  PC_WIDTH  breakpoint PC (byte address)
pc  in  PC_WIDTH  current core PC
instr  in  32  instruction currently fetched at pc
core_en  out  1  commit enable: the instruction at pc retires on this rising edge
state  out  2  0=HALT, 1=RUN, 2=STEP, 3=TRAP
halted  out  1  high when state is HALT or TRAP
break_hit  out  1  sticky: a breakpoint stopped execution
cycle_cnt  out  CNT_WIDTH  clocks since reset
retire_cnt  out  CNT_WIDTH  number of cycles with core_en=1

Behaviour:
- Reset (rst=0 at posedge):
  - state <= RUN if START_RUN=1, else HALT.
  - cycle_cnt, retire_cnt, break_hit and skip_bp <= 0.
  - Reset overrides every other input, including mid-RUN or in TRAP.
- Decode terms (combinational):
  - is_ebreak = (instr == 32'h0010_0073).
  - bp_hit = bp_en & (pc == bp_addr) & ~skip_bp.
- core_en is combinational from the current state and inputs; it is the only output that is not a register. During reset cycles core_en = 0.
- HALT:
  - core_en = 0.
  - run_req=1 -> RUN, skip_bp <= 1, break_hit <= 0.
  - Else step_req=1 -> STEP, break_hit <= 0.
  - run_req has priority over step_req. halt_req is ignored.
- RUN (priority order):
  - is_ebreak: core_en = 0 -> TRAP.
  - Else halt_req: core_en = 0 -> HALT.
  - Else bp_hit: core_en = 0 -> HALT, break_hit <= 1.
  - Else core_en = 1, stay in RUN, skip_bp <= 0.
- skip_bp guarantees that resuming from a breakpoint commits the breakpointed instruction once. It is cleared on the first RUN commit and on any exit from RUN.
- STEP:
  - is_ebreak: core_en = 0 -> TRAP.
  - Else core_en = 1 -> HALT.
  - Breakpoints, run_req, halt_req and step_req are ignored in STEP. Exactly one instruction retires per step.
- TRAP: core_en = 0. Only rst exits TRAP. All requests are ignored.
- Counters:
  - cycle_cnt += 1 every non-reset clock.
  - retire_cnt += 1 on every clock with core_en=1.
  - Both wrap modulo 2^CNT_WIDTH, with no saturation.
- halted is registered with state: halted = (state==HALT) | (state==TRAP).
- Requests are level-sampled each clock. A pulse held multiple cycles behaves as repeated requests; e.g. step_req held 4 cycles from HALT alternates STEP/HALT and retires 2 instructions.
- Latency: a request on cycle N changes state at the edge ending N; the first commit occurs in cycle N+1.

Test Plan:
1. Reset with START_RUN=0, then step_req pulse at cycle 3 (instr=ADD) -> state goes HALT,STEP,HALT; core_en=1 for exactly one cycle; retire_cnt=1; cycle_cnt=4 at cycle 4.
2. run_req, then pc advances 0,4,8 with bp_en=1, bp_addr=8 -> core_en=0 when pc=8; state=HALT; break_hit=1; retire_cnt=2. A following run_req -> pc=8 commits (skip_bp); break_hit=0; RUN continues.
3. RUN with instr=32'h0010_0073 at pc=0xC -> core_en=0; state=TRAP; run_req/step_req ignored for 10 cycles; rst=0 for one cycle -> state=HALT, both counters 0.
4. In RUN, assert halt_req and is_ebreak in the same cycle -> TRAP. Separately, halt_req together with bp_hit -> HALT with break_hit=0.
5. In HALT, assert run_req and step_req in the same cycle -> state=RUN. Apply rst mid-RUN -> HALT next cycle; core_en=0 during the reset cycle.
6. CNT_WIDTH=4: run 17 commits -> retire_cnt wraps to 1; cycle_cnt wraps to 0 after 16 clocks from reset.

Source files
------------

// File: rtl/core_exec_ctrl.sv
// core_exec_ctrl: run/halt/step/breakpoint/EBREAK commit control with cycle and retire counters
module core_exec_ctrl #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 32,
    parameter bit START_RUN = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_req,
    input  logic                 halt_req,
    input  logic                 step_req,
    input  logic                 bp_en,
    input  logic [PC_WIDTH-1:0]  bp_addr,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic [31:0]          instr,
    output logic                 core_en,
    output logic [1:0]           state,
    output logic                 halted,
    output logic                 break_hit,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] retire_cnt
);
    localparam logic [1:0] S_HALT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STEP = 2'd2;
    localparam logic [1:0] S_TRAP = 2'd3;
    localparam logic [1:0] S_INIT = START_RUN ? S_RUN : S_HALT;

    logic       skip_bp;
    logic       is_ebreak;
    logic       bp_hit;
    logic       run_stop;
    logic [1:0] nxt;

    assign is_ebreak = instr == 32'h0010_0073;
    assign bp_hit    = bp_en & (pc == bp_addr) & ~skip_bp;
    assign run_stop  = is_ebreak | halt_req | bp_hit;

    always_comb begin
        core_en = rst & (((state == S_RUN) & ~run_stop) | ((state == S_STEP) & ~is_ebreak));
        nxt = state;
        case (state)
            S_HALT:  nxt = run_req ? S_RUN : (step_req ? S_STEP : S_HALT);
            S_RUN:   nxt = is_ebreak ? S_TRAP : (run_stop ? S_HALT : S_RUN);
            S_STEP:  nxt = is_ebreak ? S_TRAP : S_HALT;
            default: nxt = S_TRAP;
        endcase
    end

    // skip_bp lets a resume from a breakpoint commit that instruction exactly once
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_INIT;
            halted     <= ~START_RUN;
            break_hit  <= 1'b0;
            skip_bp    <= 1'b0;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            state      <= nxt;
            halted     <= (nxt == S_HALT) | (nxt == S_TRAP);
            cycle_cnt  <= cycle_cnt + CNT_WIDTH'(1);
            retire_cnt <= retire_cnt + CNT_WIDTH'(core_en);
            skip_bp    <= (state == S_HALT) ? (run_req | skip_bp) : ((state == S_RUN) ? 1'b0 : skip_bp);
            break_hit  <= ((state == S_HALT) & (run_req | step_req)) ? 1'b0 :
                          ((state == S_RUN) & ~is_ebreak & ~halt_req & bp_hit) ? 1'b1 : break_hit;
        end
    end
endmodule
